fpu_class_pipe: RTL and testbench
=================================

Name: fpu_class_pipe

Overview:
- Parametrised, pipelined successor to the combinational FP classifier. Implements RISC-V FCLASS for any IEEE-754 binary format (EXP_W/MAN_W).
- Optional NaN-boxing check when the register width FLEN exceeds the format width.
- Valid/ready handshake on both sides, sideband tag carried alongside. Sits in the FPU misc-op lane between operand read and writeback arbitration.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, fraction field width (excluding hidden bit)
- FLEN, 32, operand register width; must be >= 1+EXP_W+MAN_W
- XLEN, 32, result width; must be >= 10
- STAGES, 2, pipeline depth; legal range 1..4
- TAG_W, 5, sideband tag width (destination register index)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  stage 1 can accept
- in_data  input  FLEN  operand register contents
- in_tag  input  TAG_W  sideband, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_rd  output  XLEN  FCLASS mask; bits [9:0] one-hot, rest zero
- out_idx  output  4  binary index of the set bit (0..9)
- out_tag  output  TAG_W  tag of this result

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Format width W = 1+EXP_W+MAN_W. Fields: sign = in_data[W-1], exp = in_data[W-2:MAN_W], frac = in_data[MAN_W-1:0].
- NaN-boxing: if FLEN>W and in_data[FLEN-1:W] is not all ones, the operand is the canonical qNaN. Result is bit 9 regardless of the low bits. If FLEN==W, no check.
- Class bits:
  - 0 = -inf, 1 = -normal, 2 = -subnormal, 3 = -0
  - 4 = +0, 5 = +subnormal, 6 = +normal, 7 = +inf
  - 8 = sNaN (exp all ones, frac!=0, frac MSB=0)
  - 9 = qNaN (exp all ones, frac MSB=1)
- Exactly one bit of out_rd[9:0] set whenever out_valid=1. out_rd[XLEN-1:10]=0 always.
- Pipeline:
  - Stage 1 registers the decoded flags: sign, exp_zero, exp_ones, frac_zero, qbit, box_ok.
  - The final stage registers the one-hot encode and the index.
  - Intermediate stages are pure delay. With STAGES=1, decode and encode happen in the same cycle into the single register.
- Each stage holds a valid bit. Stage k loads when it is empty or stage k+1 (or downstream, for the last stage) is taking its contents this cycle.
- in_ready = stage-1 load condition. This is a combinational ready chain from out_ready; no combinational path from in_valid to in_ready.
- Transfers occur on in_valid&&in_ready and out_valid&&out_ready.
- Latency exactly STAGES cycles with out_ready=1. Throughput 1/cycle. Bubbles collapse under backpressure. Capacity = STAGES entries. Order preserved, no drop, no duplication.
- While out_valid=1 and out_ready=0: out_rd, out_idx, out_tag hold stable.
- Reset: all stage valid bits 0.
  - Outputs: out_valid=0, out_rd=0, out_idx=0, out_tag=0.
  - in_ready=1 the cycle after reset is deasserted.
  - In-flight operands during reset are discarded. An in_valid presented in a reset cycle is not accepted.
- Simultaneous accept and emit on a full pipe: allowed, with the pipe remaining full.
- Data registers load only on the stage load condition. Data need not be cleared, but outputs are gated to zero when !out_valid.

Decomposition:
- Package fpu_class_pkg:
  - class index localparams CLS_NEG_INF..CLS_QNAN (0..9)
  - enum type fpu_class_e (4-bit)
  - packed struct fpu_class_flags_t for the stage-1 decode
- One sub-module: fpu_class_decode, combinational field split, box check and flag generation, parametrised by EXP_W/MAN_W/FLEN.
- Stage registers are generated inline in a for-generate over STAGES.

Test Plan:
- Default params, out_ready=1, stream 32'h7F800000, 32'h80000000, 32'h7F800001, 32'h7FC00000, 32'h00000001, 32'hBF800000 -> out_rd 0x080, 0x008, 0x100, 0x200, 0x020, 0x002 on consecutive cycles starting 2 cycles after the first accept. out_idx 7,3,8,9,5,1; tags match.
- FLEN=64, EXP_W=8, MAN_W=23: 64'hFFFFFFFF_3F800000 -> 0x040; 64'h00000000_3F800000 -> 0x200; 64'hFFFFFFFF_80000000 -> 0x008.
- EXP_W=11, MAN_W=52, FLEN=64: 64'hFFF0000000000000 -> 0x001; 64'h0008000000000000 -> 0x020; 64'h7FF8000000000000 -> 0x200.
- STAGES=2, hold out_ready=0, offer 4 operands back-to-back -> exactly 2 accepted, in_ready=0 thereafter, out_valid=1 with stable data. Raise out_ready -> all 4 results emerge in order at 1/cycle.
- Random in_valid/out_ready toggling, 10k random operands for STAGES=1..4 -> results match a reference model; one-hot always; FIFO order by tag.
- Assert rst for 1 cycle with 2 operands in flight -> next cycle out_valid=0, out_rd=0, in_ready=1. Those results never appear.

Source files
------------

// File: rtl/fpu_class_pkg.sv
// Shared types for the pipelined FCLASS unit: class indices, decode flags and the flag-to-class encoder.
// Pure declarations and functions; no state, no latency.
package fpu_class_pkg;

    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;
    localparam int CLS_NUM      = 10;

    typedef enum logic [3:0] {
        FC_NEG_INF  = 4'(CLS_NEG_INF),
        FC_NEG_NORM = 4'(CLS_NEG_NORM),
        FC_NEG_SUB  = 4'(CLS_NEG_SUB),
        FC_NEG_ZERO = 4'(CLS_NEG_ZERO),
        FC_POS_ZERO = 4'(CLS_POS_ZERO),
        FC_POS_SUB  = 4'(CLS_POS_SUB),
        FC_POS_NORM = 4'(CLS_POS_NORM),
        FC_POS_INF  = 4'(CLS_POS_INF),
        FC_SNAN     = 4'(CLS_SNAN),
        FC_QNAN     = 4'(CLS_QNAN)
    } fpu_class_e;

    typedef struct packed {
        logic sign;
        logic exp_zero;
        logic exp_ones;
        logic frac_zero;
        logic qbit;
        logic box_ok;
    } fpu_class_flags_t;

    // A broken NaN box overrides every other field: the operand reads as canonical qNaN.
    function automatic fpu_class_e fpu_class_encode(input fpu_class_flags_t f);
        fpu_class_e c;
        if (!f.box_ok) begin
            c = FC_QNAN;
        end else if (f.exp_ones) begin
            if (f.frac_zero) c = f.sign ? FC_NEG_INF : FC_POS_INF;
            else             c = f.qbit ? FC_QNAN : FC_SNAN;
        end else if (f.exp_zero) begin
            if (f.frac_zero) c = f.sign ? FC_NEG_ZERO : FC_POS_ZERO;
            else             c = f.sign ? FC_NEG_SUB : FC_POS_SUB;
        end else begin
            c = f.sign ? FC_NEG_NORM : FC_POS_NORM;
        end
        return c;
    endfunction

    function automatic logic [CLS_NUM-1:0] fpu_class_onehot(input fpu_class_e c);
        logic [CLS_NUM-1:0] m;
        m = {{(CLS_NUM-1){1'b0}}, 1'b1} << c;
        return m;
    endfunction

endpackage

// File: rtl/fpu_class_decode.sv
// Splits an operand register into sign/exponent/fraction and produces the FCLASS decode flags.
// Purely combinational; no handshake.
module fpu_class_decode
    import fpu_class_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FLEN  = 32
) (
    input  logic [FLEN-1:0]  data,
    output fpu_class_flags_t flags
);

    localparam int W = 1 + EXP_W + MAN_W;

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] frac_f;
    logic             box_ok;

    assign exp_f  = data[W-2:MAN_W];
    assign frac_f = data[MAN_W-1:0];

    // Narrow formats held in a wider register must be NaN-boxed with all-ones upper bits.
    generate
        if (FLEN > W) begin : g_box
            assign box_ok = &data[FLEN-1:W];
        end else begin : g_no_box
            assign box_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        flags           = '0;
        flags.sign      = data[W-1];
        flags.exp_zero  = (exp_f == '0);
        flags.exp_ones  = &exp_f;
        flags.frac_zero = (frac_f == '0);
        flags.qbit      = frac_f[MAN_W-1];
        flags.box_ok    = box_ok;
    end

endmodule

// File: rtl/fpu_class_pipe.sv
// Pipelined RISC-V FCLASS: STAGES-deep valid/ready pipe, latency STAGES, one result per cycle.
// Stalls collapse bubbles; in_ready is a combinational chain from out_ready only.
module fpu_class_pipe
    import fpu_class_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int FLEN   = 32,
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLEN-1:0]  in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rd,
    output logic [3:0]       out_idx,
    output logic [TAG_W-1:0] out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int FS = (STAGES > 1) ? STAGES - 1 : 1;

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("fpu_class_pipe: STAGES must be 1..4");
        end
        if (FLEN < W) begin : g_bad_flen
            $error("fpu_class_pipe: FLEN smaller than format width");
        end
        if (XLEN < CLS_NUM) begin : g_bad_xlen
            $error("fpu_class_pipe: XLEN must be at least 10");
        end
    endgenerate

    fpu_class_flags_t   dec_flags;
    fpu_class_flags_t   enc_src;
    fpu_class_e         enc_cls;
    fpu_class_flags_t   flg_s [FS];
    logic [TAG_W-1:0]   tag_s [STAGES];
    logic [STAGES-1:0]  vld_vec;
    logic [STAGES-1:0]  ld;
    logic [CLS_NUM-1:0] rd_r;
    logic [3:0]         idx_r;

    fpu_class_decode #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .FLEN  (FLEN)
    ) u_decode (
        .data  (in_data),
        .flags (dec_flags)
    );

    generate
        if (STAGES == 1) begin : g_enc_direct
            assign enc_src = dec_flags;
        end else begin : g_enc_piped
            assign enc_src = flg_s[STAGES-2];
        end
    endgenerate

    assign enc_cls = fpu_class_encode(enc_src);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_r;
        logic [TAG_W-1:0] tag_r;
        logic             up_vld;
        logic [TAG_W-1:0] up_tag;

        if (k == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_tag = in_tag;
        end else begin : g_link
            assign up_vld = vld_vec[k-1];
            assign up_tag = tag_s[k-1];
        end

        // Unrolled ready chain: a stage can load if any stage from here to the output
        // has a hole, or the downstream consumer is taking the head this cycle.
        assign ld[k] = out_ready || !(&vld_vec[STAGES-1:k]);

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= 1'b0;
            end else if (ld[k]) begin
                vld_r <= up_vld;
            end
        end

        always_ff @(posedge clk) begin
            if (ld[k]) begin
                tag_r <= up_tag;
            end
        end

        assign vld_vec[k] = vld_r;
        assign tag_s[k]   = tag_r;

        if (k < STAGES - 1) begin : g_flags
            fpu_class_flags_t flg_r;
            fpu_class_flags_t up_flg;

            if (k == 0) begin : g_from_dec
                assign up_flg = dec_flags;
            end else begin : g_from_prev
                assign up_flg = flg_s[k-1];
            end

            always_ff @(posedge clk) begin
                if (ld[k]) begin
                    flg_r <= up_flg;
                end
            end

            assign flg_s[k] = flg_r;
        end else begin : g_encode
            always_ff @(posedge clk) begin
                if (ld[k]) begin
                    rd_r  <= fpu_class_onehot(enc_cls);
                    idx_r <= enc_cls;
                end
            end
        end
    end

    // Nothing is taken while reset is held, so upstream must not see a ready then.
    assign in_ready  = ld[0] && !rst;
    assign out_valid = vld_vec[STAGES-1];
    assign out_rd    = out_valid ? XLEN'(rd_r) : '0;
    assign out_idx   = out_valid ? idx_r : 4'd0;
    assign out_tag   = out_valid ? tag_s[STAGES-1] : '0;

endmodule

// File: tb/tb_fpu_class_pipe.sv
// Bench for fpu_class_pipe: four configurations (2-stage single, 3-stage boxed single,
// 4-stage double, 1-stage single) checked by a shared scoreboard fed from tables and a reference model.
module tb_fpu_class_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv   [4];
    logic        ir   [4];
    logic [63:0] id   [4];
    logic [4:0]  it   [4];
    logic        ov   [4];
    logic        orr  [4];
    logic [31:0] ord  [4];
    logic [3:0]  oi   [4];
    logic [4:0]  ot   [4];

    fpu_class_pipe u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][31:0]),
        .in_tag(it[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_rd(ord[0]),
        .out_idx(oi[0]), .out_tag(ot[0])
    );
    fpu_class_pipe #(.EXP_W(8), .MAN_W(23), .FLEN(64), .STAGES(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_tag(it[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_rd(ord[1]),
        .out_idx(oi[1]), .out_tag(ot[1])
    );
    fpu_class_pipe #(.EXP_W(11), .MAN_W(52), .FLEN(64), .STAGES(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_tag(it[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_rd(ord[2]),
        .out_idx(oi[2]), .out_tag(ot[2])
    );
    fpu_class_pipe #(.STAGES(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3][31:0]),
        .in_tag(it[3]), .out_valid(ov[3]), .out_ready(orr[3]), .out_rd(ord[3]),
        .out_idx(oi[3]), .out_tag(ot[3])
    );

    int n_cmp;
    int n_bad;
    int cyc;
    int stg [4] = '{2, 3, 4, 1};

    logic [31:0] sb_rd  [4][256];
    logic [3:0]  sb_idx [4][256];
    logic [4:0]  sb_tag [4][256];
    int          sb_cyc [4][256];
    int          wp [4];
    int          rp [4];
    int          tag_cnt [4];
    logic [31:0] pend_rd  [4];
    logic [3:0]  pend_idx [4];
    bit          acc [4];
    bit          chk_lat;
    bit          pstall [4];
    logic [31:0] p_rd  [4];
    logic [3:0]  p_idx [4];
    logic [4:0]  p_tag [4];

    typedef struct {
        int          d;
        logic [63:0] data;
        logic [31:0] rd;
        logic [3:0]  idx;
    } vec_t;
    vec_t tab [13];
    vec_t bp  [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int fmt_exp(int d);  return (d == 2) ? 11 : 8;  endfunction
    function automatic int fmt_man(int d);  return (d == 2) ? 52 : 23; endfunction
    function automatic int fmt_flen(int d); return (d == 1 || d == 2) ? 64 : 32; endfunction

    // Reference classifier straight from the IEEE field definitions.
    function automatic int ref_class(int d, logic [63:0] x);
        int ew, mw, fl, w;
        logic [63:0] e, f, emax;
        bit s;
        ew = fmt_exp(d); mw = fmt_man(d); fl = fmt_flen(d); w = 1 + ew + mw;
        if (fl > w && (x >> w) != ({64{1'b1}} >> w)) return 9;
        s    = x[w-1];
        emax = (64'd1 << ew) - 1;
        e    = (x >> mw) & emax;
        f    = x & ((64'd1 << mw) - 1);
        if (e == emax) begin
            if (f == 0) return s ? 0 : 7;
            return ((f >> (mw - 1)) != 0) ? 9 : 8;
        end
        if (e == 0) begin
            if (f == 0) return s ? 3 : 4;
            return s ? 2 : 5;
        end
        return s ? 1 : 6;
    endfunction

    function automatic logic [63:0] rand_op(int d);
        int ew, mw, fl, w;
        logic [63:0] e, f, x, r;
        ew = fmt_exp(d); mw = fmt_man(d); fl = fmt_flen(d); w = 1 + ew + mw;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       e = 0;
            1:       e = (64'd1 << ew) - 1;
            default: e = r & ((64'd1 << ew) - 1);
        endcase
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       f = 0;
            1:       f = 64'd1 << (mw - 1);
            default: f = r & ((64'd1 << mw) - 1);
        endcase
        x = (64'($urandom_range(0, 1)) << (w - 1)) | (e << mw) | f;
        if (fl > w) begin
            r = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) x = x | ({64{1'b1}} << w);
            else                            x = x | ((r >> w) << w);
        end
        return x;
    endfunction

    // One clock: sample at negedge+1, score handshakes, then advance to the next negedge.
    task automatic step();
        int j;
        #1;
        for (int d = 0; d < 4; d++) begin
            acc[d] = iv[d] && ir[d];
            if (pstall[d]) begin
                chk($sformatf("dut%0d stall_valid", d), 64'(ov[d]), 64'd1);
                chk($sformatf("dut%0d stall_rd", d), 64'(ord[d]), 64'(p_rd[d]));
                chk($sformatf("dut%0d stall_idx", d), 64'(oi[d]), 64'(p_idx[d]));
                chk($sformatf("dut%0d stall_tag", d), 64'(ot[d]), 64'(p_tag[d]));
            end
            if (!ov[d]) begin
                chk($sformatf("dut%0d idle_zero", d), {28'd0, ord[d], oi[d]}, 64'd0);
                chk($sformatf("dut%0d idle_tag", d), 64'(ot[d]), 64'd0);
            end else begin
                chk($sformatf("dut%0d onehot", d),
                    64'($countones(ord[d][9:0]) == 1 && ord[d][31:10] == 22'd0), 64'd1);
                if (orr[d]) begin
                    if (rp[d] == wp[d]) begin
                        n_cmp++; n_bad++;
                        $display("FAIL dut%0d unexpected_output: got idx %0d tag %0d, required none",
                                 d, oi[d], ot[d]);
                    end else begin
                        j = rp[d] % 256;
                        chk($sformatf("dut%0d rd", d), 64'(ord[d]), 64'(sb_rd[d][j]));
                        chk($sformatf("dut%0d idx", d), 64'(oi[d]), 64'(sb_idx[d][j]));
                        chk($sformatf("dut%0d tag", d), 64'(ot[d]), 64'(sb_tag[d][j]));
                        if (chk_lat)
                            chk($sformatf("dut%0d latency", d), 64'(cyc - sb_cyc[d][j]), 64'(stg[d]));
                        rp[d]++;
                    end
                end
            end
            if (acc[d]) begin
                j = wp[d] % 256;
                sb_rd[d][j]  = pend_rd[d];
                sb_idx[d][j] = pend_idx[d];
                sb_tag[d][j] = it[d];
                sb_cyc[d][j] = cyc;
                wp[d]++;
                tag_cnt[d]++;
            end
            pstall[d] = ov[d] && !orr[d];
            p_rd[d]   = ord[d];
            p_idx[d]  = oi[d];
            p_tag[d]  = ot[d];
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int d = 0; d < 4; d++) begin
            iv[d]  = 1'b0;
            orr[d] = 1'b1;
        end
    endtask

    task automatic drive(input int d, input logic [63:0] x, input logic [31:0] rd, input logic [3:0] idx);
        iv[d]       = 1'b1;
        id[d]       = x;
        it[d]       = 5'(tag_cnt[d]);
        pend_rd[d]  = rd;
        pend_idx[d] = idx;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p;
        tab[0]  = '{0, 64'h7F800000, 32'h080, 4'd7};
        tab[1]  = '{0, 64'h80000000, 32'h008, 4'd3};
        tab[2]  = '{0, 64'h7F800001, 32'h100, 4'd8};
        tab[3]  = '{0, 64'h7FC00000, 32'h200, 4'd9};
        tab[4]  = '{0, 64'h00000001, 32'h020, 4'd5};
        tab[5]  = '{0, 64'hBF800000, 32'h002, 4'd1};
        tab[6]  = '{1, 64'hFFFFFFFF_3F800000, 32'h040, 4'd6};
        tab[7]  = '{1, 64'h00000000_3F800000, 32'h200, 4'd9};
        tab[8]  = '{1, 64'hFFFFFFFF_80000000, 32'h008, 4'd3};
        tab[9]  = '{2, 64'hFFF0000000000000, 32'h001, 4'd0};
        tab[10] = '{2, 64'h0008000000000000, 32'h020, 4'd5};
        tab[11] = '{2, 64'h7FF8000000000000, 32'h200, 4'd9};
        tab[12] = '{3, 64'h00000000, 32'h010, 4'd4};
        bp[0]   = '{0, 64'h3F800000, 32'h040, 4'd6};
        bp[1]   = '{0, 64'hFF800000, 32'h001, 4'd0};
        bp[2]   = '{0, 64'h00000000, 32'h010, 4'd4};
        bp[3]   = '{0, 64'h80000001, 32'h004, 4'd2};

        n_cmp = 0; n_bad = 0; cyc = 0; chk_lat = 1'b0;
        for (int d = 0; d < 4; d++) begin
            wp[d] = 0; rp[d] = 0; tag_cnt[d] = 0; pstall[d] = 1'b0;
            id[d] = '0; it[d] = '0; pend_rd[d] = '0; pend_idx[d] = '0;
        end
        idle_all();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("dut%0d reset_in_ready", d), 64'(ir[d]), 64'd1);
            chk($sformatf("dut%0d reset_out_valid", d), 64'(ov[d]), 64'd0);
            chk($sformatf("dut%0d reset_outputs", d), {23'd0, ord[d], oi[d], ot[d]}, 64'd0);
        end
        @(negedge clk);

        // Directed vectors, back-to-back per configuration, with exact latency.
        chk_lat = 1'b1;
        for (int i = 0; i < 13; i++) begin
            idle_all();
            drive(tab[i].d, tab[i].data, tab[i].rd, tab[i].idx);
            step();
            chk($sformatf("dut%0d table_accept %0d", tab[i].d, i), 64'(acc[tab[i].d]), 64'd1);
        end
        idle_all();
        repeat (8) step();

        // Backpressure on the 2-stage pipe: only two fit, then release.
        chk_lat = 1'b0;
        orr[0] = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, bp[k].data, bp[k].rd, bp[k].idx);
            step();
            if (acc[0]) k++;
        end
        chk("bp_accepted_while_stalled", 64'(k), 64'd2);
        chk("bp_in_ready_full", 64'(ir[0]), 64'd0);
        chk("bp_out_valid_full", 64'(ov[0]), 64'd1);
        orr[0] = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            drive(0, bp[k].data, bp[k].rd, bp[k].idx);
            step();
            if (acc[0]) k++;
        end
        chk("bp_accepted_total", 64'(k), 64'd4);
        idle_all();
        repeat (6) step();
        chk("bp_all_emitted", 64'(rp[0]), 64'(wp[0]));

        // Reset with two operands in flight; they must never appear.
        orr[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(0, bp[c].data, bp[c].rd, bp[c].idx);
            step();
        end
        chk("rst_pipe_full", 64'(ov[0]), 64'd1);
        rst = 1'b1;
        drive(0, bp[2].data, bp[2].rd, bp[2].idx);
        @(negedge clk);
        rst = 1'b0;
        idle_all();
        for (int d = 0; d < 4; d++) begin
            rp[d] = wp[d];
            pstall[d] = 1'b0;
        end
        #1;
        chk("rst_flush_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_flush_out_rd", 64'(ord[0]), 64'd0);
        chk("rst_flush_in_ready", 64'(ir[0]), 64'd1);
        @(negedge clk);
        repeat (6) step();

        // Random traffic on every configuration against the reference model.
        for (int c = 0; c < 12000; c++) begin
            p = 3 + 3 * ((c / 2000) % 3);
            for (int d = 0; d < 4; d++) begin
                logic [63:0] x;
                int          cls;
                x   = rand_op(d);
                cls = ref_class(d, x);
                drive(d, x, 32'd1 << cls, 4'(cls));
                iv[d]  = ($urandom_range(0, 9) < 7);
                orr[d] = ($urandom_range(0, 9) < p);
            end
            step();
        end
        idle_all();
        repeat (10) step();
        for (int d = 0; d < 4; d++)
            chk($sformatf("dut%0d drain_complete", d), 64'(rp[d]), 64'(wp[d]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
